// File: rtl/edge_chk_pkg.sv
// Shared types and helpers for the edge implication checker.
package edge_chk_pkg;

  typedef enum logic [1:0] {
    ROSE    = 2'd0,
    FELL    = 2'd1,
    STABLE  = 2'd2,
    CHANGED = 2'd3
  } edge_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_e;

  function automatic logic edge_match(input edge_mode_e m, input logic prev, input logic cur);
    logic hit;
    hit = 1'b0;
    unique case (m)
      ROSE:    hit = !prev && cur;
      FELL:    hit = prev && !cur;
      STABLE:  hit = (prev == cur);
      CHANGED: hit = (prev != cur);
    endcase
    return hit;
  endfunction

  // Callers zero-extend narrower operands; max is the all-ones value of the real width.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/edge_impl_checker_if.sv
// Monitor-facing bundle: per-channel stimulus in, pulses/flags/counters out.
interface edge_impl_checker_if #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned MAX_DLY = 7,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned DLY_W = $clog2(MAX_DLY + 1);

  logic [NCH-1:0]       en;
  logic                 clr;
  logic [NCH-1:0]       ant_i;
  logic [NCH-1:0]       sig_i;
  logic [2*NCH-1:0]     mode_i;
  logic [DLY_W*NCH-1:0] dly_i;
  logic [NCH-1:0]       pass_o;
  logic [NCH-1:0]       fail_o;
  logic [NCH-1:0]       sticky_fail_o;
  logic                 any_fail_o;
  logic [CNT_W-1:0]     pass_cnt_o;
  logic [CNT_W-1:0]     fail_cnt_o;

  modport master (
    output en, clr, ant_i, sig_i, mode_i, dly_i,
    input  pass_o, fail_o, sticky_fail_o, any_fail_o, pass_cnt_o, fail_cnt_o
  );

  modport slave (
    input  en, clr, ant_i, sig_i, mode_i, dly_i,
    output pass_o, fail_o, sticky_fail_o, any_fail_o, pass_cnt_o, fail_cnt_o
  );
endinterface

// File: rtl/edge_chk_chan.sv
// One channel of "ant |-> ##[0:D] edge(sig)". EDGE_CHK_VACUOUS_PASS_EN makes
// enabled IDLE cycles without antecedent report a pass.
module edge_chk_chan
  import edge_chk_pkg::*;
#(
  parameter int unsigned MAX_DLY = 7,
  localparam int unsigned DLY_W  = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             ant_i,
  input  logic             sig_i,
  input  edge_mode_e       mode_i,
  input  logic [DLY_W-1:0] dly_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic             pass_nxt_o,
  output logic             fail_nxt_o
);

  chan_state_e      state_q, state_d;
  edge_mode_e       mode_q, mode_d;
  logic [DLY_W-1:0] rem_q, rem_d;
  logic [DLY_W-1:0] dly_c;
  logic             prev_q;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  if (MAX_DLY < (2 ** DLY_W) - 1) begin : g_clamp
    assign dly_c = (dly_i > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY) : dly_i;
  end else begin : g_noclamp
    assign dly_c = dly_i;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i && ant_i) begin
          mode_d = mode_i;
          if (edge_match(mode_i, prev_q, sig_i)) begin
            pass_d = 1'b1;
          end else if (dly_c == '0) begin
            fail_d = 1'b1;
          end else begin
            state_d = WAIT;
            rem_d   = dly_c;
          end
        end
`ifdef EDGE_CHK_VACUOUS_PASS_EN
        else if (en_i) begin
          pass_d = 1'b1;
        end
`endif
      end
      WAIT: begin
        // Antecedent is ignored here; only the latched mode/window matter.
        if (!en_i) begin
          state_d = IDLE;
        end else if (edge_match(mode_q, prev_q, sig_i)) begin
          pass_d  = 1'b1;
          state_d = IDLE;
        end else if (rem_q == DLY_W'(1)) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rem_d = rem_q - DLY_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ROSE;
      rem_q   <= '0;
      prev_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      prev_q  <= sig_i;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign pass_nxt_o = pass_d;
  assign fail_nxt_o = fail_d;

endmodule

// File: rtl/edge_impl_checker.sv
// Multi-channel edge implication monitor with sticky fails and saturating counters.
// Optional vacuous-pass reporting is enabled by defining EDGE_CHK_VACUOUS_PASS_EN.
module edge_impl_checker
  import edge_chk_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned MAX_DLY = 7,
  parameter int unsigned CNT_W   = 16
) (
  input logic                clk,
  input logic                rst_n,
  edge_impl_checker_if.slave bus
);

  localparam int unsigned DLY_W = $clog2(MAX_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   pass_w, fail_w, pass_nxt, fail_nxt;
  logic [NCH-1:0]   sticky_q;
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
  logic [31:0]      pass_pop, fail_pop;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    edge_chk_chan #(.MAX_DLY(MAX_DLY)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (bus.en[g]),
      .ant_i     (bus.ant_i[g]),
      .sig_i     (bus.sig_i[g]),
      .mode_i    (edge_mode_e'(bus.mode_i[2*g +: 2])),
      .dly_i     (bus.dly_i[DLY_W*g +: DLY_W]),
      .pass_o    (pass_w[g]),
      .fail_o    (fail_w[g]),
      .pass_nxt_o(pass_nxt[g]),
      .fail_nxt_o(fail_nxt[g])
    );
  end

  always_comb begin
    pass_pop = '0;
    fail_pop = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      pass_pop = pass_pop + 32'(pass_nxt[i]);
      fail_pop = fail_pop + 32'(fail_nxt[i]);
    end
  end

  // Counting the next-cycle pulses keeps counters/sticky aligned with pass_o/fail_o,
  // so a clr sampled on the same edge that launches pulses drops them from the tally.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      sticky_q   <= '0;
    end else begin
      pass_cnt_q <= CNT_W'(sat_add(32'(pass_cnt_q), pass_pop, 32'(CNT_MAX)));
      fail_cnt_q <= CNT_W'(sat_add(32'(fail_cnt_q), fail_pop, 32'(CNT_MAX)));
      sticky_q   <= sticky_q | fail_nxt;
    end
  end

  assign bus.pass_o        = pass_w;
  assign bus.fail_o        = fail_w;
  assign bus.sticky_fail_o = sticky_q;
  assign bus.any_fail_o    = |sticky_q;
  assign bus.pass_cnt_o    = pass_cnt_q;
  assign bus.fail_cnt_o    = fail_cnt_q;

endmodule

// File: doc/edge_impl_checker.md
Name: edge_impl_checker

Overview:
Synthesizable multi-channel implication checker: per channel, evaluates "ant |-> ##[0:D] edge(sig)", where edge is rose/fell/stable/changed and D is a bounded window. It generalises the single-signal $fell implication check into hardware usable in emulation and silicon debug. Produces per-channel pass/fail pulses, sticky fail flags and saturating global pass/fail counters. Sits beside the design under observation as a passive monitor.

Parameters:
NCH, 4, number of independent channels
MAX_DLY, 7, maximum window length D in cycles
CNT_W, 16, width of global pass/fail counters
DLY_W (localparam), $clog2(MAX_DLY+1), width of one window field

Ports:
clk  in  1  clock; all sampling on posedge
rst_n  in  1  synchronous active-low reset
en  in  NCH  per-channel enable
clr  in  1  synchronous clear of counters and sticky flags
ant_i  in  NCH  antecedent per channel
sig_i  in  NCH  observed signal per channel
mode_i  in  2*NCH  per-channel edge mode; 0=ROSE 1=FELL 2=STABLE 3=CHANGED
dly_i  in  DLY_W*NCH  per-channel window D; values >MAX_DLY clamp to MAX_DLY
pass_o  out  NCH  one-cycle pass pulse
fail_o  out  NCH  one-cycle fail pulse
sticky_fail_o  out  NCH  set on any fail, held until clr/reset
any_fail_o  out  1  OR of sticky_fail_o
pass_cnt_o  out  CNT_W  total passes, saturating
fail_cnt_o  out  CNT_W  total fails, saturating

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, every channel IDLE, prev-sample regs 0, counters 0. Reset mid-window drops pending checks with no pulse.
- Per-channel prev reg <= sig_i every cycle, independent of en. Edge at cycle k: ROSE !prev&cur; FELL prev&!cur; STABLE prev==cur; CHANGED prev!=cur.
- Channel FSM: IDLE, WAIT. Mode and D are latched when the antecedent is accepted in IDLE. In WAIT, the latched values are used; input changes are ignored.
- IDLE, en=1, ant=1:
  - edge true -> pass.
  - else D==0 -> fail.
  - else -> WAIT, rem=D.
- WAIT:
  - edge true -> pass, IDLE.
  - else rem==1 -> fail, IDLE.
  - else rem-=1.
  - ant during WAIT is ignored (non-overlapping). A fresh check needs ant in a later IDLE cycle.
- en=0: channel forced to IDLE next cycle; pending check discarded silently; no pulses.
- Latency: pass_o/fail_o registered; asserted for exactly one cycle, the cycle after the deciding sample. Never both asserted on one channel.
- sticky_fail_o[i] set with fail_o[i].
- Counters: add popcount(pass_o) and popcount(fail_o) each cycle; saturate at 2^CNT_W-1, no wrap.
- clr: zeroes counters and sticky flags. If clr coincides with new pulses, clr wins for that cycle; pulses are still output but not counted. FSMs are unaffected.

Optional Feature:
Macro EDGE_CHK_VACUOUS_PASS_EN.
- Defined: an IDLE, en=1, ant=0 cycle is a vacuous pass. It raises pass_o and is counted, matching simulator assert-pass semantics.
- Undefined: vacuous cycles produce no pulse and no count.

Decomposition:
- Package edge_chk_pkg: edge_mode_e enum (ROSE/FELL/STABLE/CHANGED, 2-bit), chan_state_e enum (IDLE/WAIT), and a saturating-add function.
- Sub-module edge_chk_chan: prev reg, edge decode, FSM, rem counter, pulses.
- Top generates NCH instances and holds counters, popcount and sticky logic.

Test Plan:
- ch0 FELL, D=0, en=1; samples (ant,sig) = (0,1),(1,0),(1,1),(0,0),(1,1) -> pass at sample 2, fails at samples 3 and 5; pass_cnt=1, fail_cnt=2, sticky_fail_o[0]=1 (macro off).
- ch1 ROSE, D=3; ant pulse at k, sig rises at k+2 -> pass_o[1] at k+3, no fail. Repeat with no rise -> fail_o[1] at k+4.
- ch2 CHANGED, D=2; ant at k with dly_i changed to 0 at k+1 -> latched D=2 used. Second ant at k+1 ignored; exactly one pulse.
- All 4 channels fail in the same cycle with CNT_W=2 and fail_cnt=2 -> fail_cnt=3 (saturated); clr next cycle -> counters 0, any_fail_o=0.
- Channel in WAIT: rst_n=0 for one cycle -> no pulse, state IDLE, prev=0. Separately, en dropped mid-window -> no pulse, no count.
- EDGE_CHK_VACUOUS_PASS_EN defined; 10 cycles ant=0 on ch0 -> 10 pass pulses, pass_cnt=10.
